// File: rtl/picomips_core.sv
// picomips_core: parametrised accumulator processor with run-time writable
// program RAM, branches, HALT, saturating arithmetic and a sticky overflow flag.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> WB (4 cycles). HEI may
// linger in EXEC. STOP is the program-load state; HALTED waits for run=0.
//
// Ports:
//   Clock, nReset          clock, asynchronous active-low reset
//   run                    1 = execute, 0 = stop / program mode
//   sw_data, sw_flag       switch operand (LSW) and handshake switch (HEI)
//   prog_we/addr/data      program RAM write port, honoured only in STOP
//   acc_out, pc_out        accumulator and program counter (registered)
//   busy, halted, ovf      status: executing, halted, sticky saturation
module picomips_core #(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 4,
  parameter int PROG_DEPTH = 32,
  parameter int FRAC_W     = 2,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              run,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_flag,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [15:0]       prog_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [AW-1:0]     pc_out,
  output logic              busy,
  output logic              halted,
  output logic              ovf
);
  localparam int RW = $clog2(NREGS);
  // Wide enough for the full product plus one guard bit.
  localparam int WW = 2*DATA_W + 1;
  localparam logic signed [WW-1:0] MAXV = WW'((1 << (DATA_W-1)) - 1);
  localparam logic signed [WW-1:0] MINV = ~MAXV;

  localparam logic [3:0] OP_LSW = 4'd1, OP_LDI = 4'd2, OP_ADD = 4'd3,
                         OP_ADDI = 4'd4, OP_MULI = 4'd5, OP_ATR = 4'd6,
                         OP_RTA = 4'd7, OP_HEI = 4'd8, OP_BRA = 4'd9,
                         OP_BNZ = 4'd10, OP_BNEG = 4'd11, OP_HALT = 4'd12;

  typedef enum logic [2:0] {S_STOP, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d, rop_q, rop_d, res_q, res_d;
  logic              ovf_q, ovf_d, sat_q, sat_d, take_q, take_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [15:0]       mem [PROG_DEPTH];
  logic [15:0]       rd_q;

  logic [3:0]        op;
  logic              busy_int;
  logic signed [DATA_W-1:0] imm;
  logic signed [WW-1:0]     a_w, i_w, r_w, s_w, full;
  logic [DATA_W-1:0] exec_res;
  logic              exec_sat, exec_take;

  // Operand bits beyond the fields this configuration decodes.
  logic unused_ir;
  assign unused_ir = ^ir_q;

  assign op       = ir_q[15:12];
  assign busy_int = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC)  || (state_q == S_WB);

  // Program RAM: writes only while stopped, synchronous read in FETCH.
  always_ff @(posedge Clock) begin
    if (prog_we && state_q == S_STOP) mem[prog_addr] <= prog_data;
    if (state_q == S_FETCH) rd_q <= mem[pc_q];
  end

  // Execute datapath: everything evaluated at full precision, then clamped.
  always_comb begin
    imm = DATA_W'(signed'(ir_q[7:0]));
    a_w = WW'(signed'(acc_q));
    i_w = WW'(imm);
    r_w = WW'(signed'(rop_q));
    s_w = WW'(signed'(sw_data));
    case (op)
      OP_LSW:  full = s_w;
      OP_LDI:  full = i_w;
      OP_ADD:  full = a_w + r_w;
      OP_ADDI: full = a_w + i_w;
      OP_MULI: full = (a_w * i_w) >>> FRAC_W;  // arithmetic shift = floor
      OP_RTA:  full = r_w;
      default: full = a_w;
    endcase
    exec_sat = 1'b0;
    if (full > MAXV) begin
      exec_res = MAXV[DATA_W-1:0];
      exec_sat = 1'b1;
    end else if (full < MINV) begin
      exec_res = MINV[DATA_W-1:0];
      exec_sat = 1'b1;
    end else begin
      exec_res = full[DATA_W-1:0];
    end
    case (op)
      OP_BRA:  exec_take = 1'b1;
      OP_BNZ:  exec_take = (acc_q != '0);
      OP_BNEG: exec_take = acc_q[DATA_W-1];
      default: exec_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ir_d    = ir_q;
    rop_d   = rop_q;
    res_d   = res_q;
    sat_d   = sat_q;
    take_d  = take_q;
    regs_d  = regs_q;
    // Dropping run abandons the in-flight instruction with no writes.
    if (busy_int && !run) begin
      state_d = S_STOP;
    end else begin
      case (state_q)
        S_STOP: if (run) begin
          state_d = S_FETCH;
          pc_d    = '0;
          ovf_d   = 1'b0;
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          ir_d    = rd_q;
          rop_d   = regs_q[rd_q[RW-1:0]];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          res_d  = exec_res;
          sat_d  = exec_sat;
          take_d = exec_take;
          if (!(op == OP_HEI && sw_flag == ir_q[0])) state_d = S_WB;
        end
        S_WB: begin
          if (op inside {OP_LSW, OP_LDI, OP_ADD, OP_ADDI, OP_MULI, OP_RTA}) acc_d = res_q;
          if (sat_q) ovf_d = 1'b1;
          if (op == OP_ATR) regs_d[ir_q[RW-1:0]] = acc_q;
          if (op == OP_HALT) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
            pc_d    = take_q ? ir_q[AW-1:0] : pc_q + 1'b1;
          end
        end
        S_HALTED: if (!run) state_d = S_STOP;
        default:  state_d = S_STOP;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_STOP;
      pc_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ir_q    <= '0;
      rop_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      take_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      ir_q    <= ir_d;
      rop_q   <= rop_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      take_q  <= take_d;
      regs_q  <= regs_d;
    end
  end

  assign acc_out = acc_q;
  assign pc_out  = pc_q;
  assign busy    = busy_int;
  assign halted  = (state_q == S_HALTED);
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_picomips_core.sv
// Bench for picomips_core: instruction-level reference model advanced once per
// clock, compared on every negedge, plus directed programs with literal results.
module tb_picomips_core;
  localparam int DW = 8, NR = 4, PD = 32, FW = 2, AW = 5;
  localparam int MAXI = (1 << (DW-1)) - 1;
  localparam int MINI = -(1 << (DW-1));

  logic Clock = 1'b0, nReset = 1'b0, run = 1'b0, sw_flag = 1'b0, prog_we = 1'b0;
  logic [DW-1:0] sw_data = '0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [DW-1:0] acc_out;
  logic [AW-1:0] pc_out;
  logic          busy, halted, ovf;

  int n_tests = 0, n_fail = 0;
  int wa;

  picomips_core #(.DATA_W(DW), .NREGS(NR), .PROG_DEPTH(PD), .FRAC_W(FW)) dut (
    .Clock(Clock), .nReset(nReset), .run(run), .sw_data(sw_data), .sw_flag(sw_flag),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .acc_out(acc_out), .pc_out(pc_out), .busy(busy), .halted(halted), .ovf(ovf));

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_STOP = 0, M_RUN = 1, M_HALT = 2;
  logic [15:0] mmem [PD];
  int m_acc, m_pc, m_ph, m_sw, m_mode;
  int m_regs [NR];
  bit m_ovf;

  function automatic int clamp(input int v);
    if (v > MAXI) return MAXI;
    if (v < MINI) return MINI;
    return v;
  endfunction

  function automatic int sx8(input logic [7:0] b);
    int u;
    u = int'(b);
    return (u >= 128) ? u - 256 : u;
  endfunction

  function automatic int floor_div(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  // Architectural effect of the instruction at m_pc, applied at its last cycle.
  task automatic m_retire();
    logic [15:0] w;
    int op, imm, idx, r, nv;
    bit take;
    w = mmem[m_pc];
    op = int'(w[15:12]);
    imm = sx8(w[7:0]);
    idx = int'(w[1:0]);
    r = m_regs[idx];
    nv = m_acc;
    take = 0;
    case (op)
      1:  nv = m_sw;
      2:  nv = imm;
      3:  nv = m_acc + r;
      4:  nv = m_acc + imm;
      5:  nv = floor_div(m_acc * imm, 1 << FW);
      6:  m_regs[idx] = m_acc;
      7:  nv = r;
      9:  take = 1;
      10: take = (m_acc != 0);
      11: take = (m_acc < 0);
      default: ;
    endcase
    if (clamp(nv) != nv) m_ovf = 1;
    m_acc = clamp(nv);
    if (op == 12) m_mode = M_HALT;
    else begin
      m_pc = take ? int'(w[4:0]) : (m_pc + 1) % PD;
      m_ph = 0;
    end
  endtask

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_acc = 0; m_pc = 0; m_ovf = 0; m_mode = M_STOP; m_ph = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
    end else begin
      case (m_mode)
        M_STOP: begin
          if (prog_we) mmem[prog_addr] = prog_data;
          if (run) begin m_mode = M_RUN; m_ph = 0; m_pc = 0; m_ovf = 0; end
        end
        M_RUN: begin
          if (!run) m_mode = M_STOP;
          else if (m_ph == 2) begin
            // third cycle: HEI holds while the flag matches; operands sampled on leaving
            if (!(mmem[m_pc][15:12] == 4'd8 && sw_flag == mmem[m_pc][0])) begin
              m_sw = $signed(sw_data);
              m_ph = 3;
            end
          end else if (m_ph == 3) m_retire();
          else m_ph++;
        end
        default: if (!run) m_mode = M_STOP;
      endcase
    end
  end

  always @(negedge Clock) begin
    if (nReset) begin
      chk("acc", int'($signed(acc_out)), m_acc);
      chk("pc", int'(pc_out), m_pc);
      chk("busy", int'(busy), int'(m_mode == M_RUN));
      chk("halted", int'(halted), int'(m_mode == M_HALT));
      chk("ovf", int'(ovf), int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(negedge Clock);
    prog_we = 1'b0;
  endtask

  task automatic w(input logic [15:0] d);
    wr(wa, d);
    wa++;
  endtask

  task automatic stop();
    run = 1'b0;
    cyc(2);
    wa = 0;
  endtask

  task automatic wait_pc(input int t, input int budget, input string nm);
    int k;
    k = 0;
    while (int'(pc_out) != t && k < budget) begin @(negedge Clock); k++; end
    chk(nm, int'(pc_out), t);
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int k;
    k = 0;
    while (!halted && k < budget) begin @(negedge Clock); k++; end
    chk(nm, int'(halted), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] rop;
    #1;
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge Clock);
    nReset = 1'b1;
    wa = 0;

    // wrap: all NOP
    for (int a = 0; a < PD; a++) w(16'h0000);
    run = 1'b1;
    wait_pc(31, 200, "wrap_reach31");
    wait_pc(0, 8, "wrap_to0");
    chk("wrap_busy", int'(busy), 1);

    // affine program with HEI handshakes
    stop();
    w(16'h8000); w(16'h1000); w(16'h5003); w(16'h6000);
    w(16'h1000); w(16'h50FE); w(16'h6001); w(16'h8001);
    w(16'h8000); w(16'h1000); w(16'h5002); w(16'h3000);
    w(16'h4014); w(16'h8001); w(16'h1000); w(16'h5003);
    w(16'h3001); w(16'h40EC); w(16'hC000);
    sw_data = 8'd40; sw_flag = 1'b0; run = 1'b1;
    cyc(10);
    chk("hei_hold_pc", int'(pc_out), 0);
    sw_flag = 1'b1;
    wait_pc(7, 100, "aff_pc7");
    cyc(6);
    sw_data = 8'd20; sw_flag = 1'b0;
    wait_pc(8, 20, "aff_pc8");
    cyc(6);
    sw_flag = 1'b1;
    wait_pc(13, 60, "aff_pc13");
    cyc(6);
    chk("aff_60", int'($signed(acc_out)), 60);
    sw_flag = 1'b0;
    wait_halt(60, "aff_halt");
    chk("aff_m25", int'($signed(acc_out)), -25);
    chk("aff_pc18", int'(pc_out), 18);

    // saturation
    stop();
    sw_flag = 1'b0;
    w(16'h2064); w(16'h4064); w(16'h8000); w(16'h2080); w(16'h50FC); w(16'hC000);
    run = 1'b1;
    wait_pc(2, 20, "sat_pc2");
    cyc(6);
    chk("sat_add127", int'($signed(acc_out)), 127);
    chk("sat_add_ovf", int'(ovf), 1);
    sw_flag = 1'b1;
    wait_halt(40, "sat_halt");
    chk("sat_mul127", int'($signed(acc_out)), 127);
    chk("sat_mul_ovf", int'(ovf), 1);
    run = 1'b0;
    cyc(2);
    chk("sat_stop_ovf", int'(ovf), 1);
    run = 1'b1;
    cyc(1);
    chk("sat_clear_ovf", int'(ovf), 0);

    // loop / branch with cycle count
    stop();
    w(16'h2005); w(16'h40FF); w(16'hA001); w(16'hC000);
    run = 1'b1;
    k = 0;
    while (!halted && k < 100) begin @(negedge Clock); k++; end
    chk("loop_cycles", k, 49);
    chk("loop_acc", int'($signed(acc_out)), 0);
    chk("loop_pc", int'(pc_out), 3);

    // mid-operation stop and program write gating
    stop();
    w(16'h2007); w(16'h4005); w(16'hC000);
    run = 1'b1;
    cyc(7);
    run = 1'b0;
    cyc(1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_acc", int'($signed(acc_out)), 7);
    chk("mid_pc", int'(pc_out), 1);
    wr(1, 16'h4001);
    run = 1'b1;
    cyc(1);
    wr(1, 16'h4010);
    wait_halt(40, "mid_halt1");
    chk("mid_newword", int'($signed(acc_out)), 8);
    stop();
    run = 1'b1;
    wait_halt(40, "mid_halt2");
    chk("mid_busy_we", int'($signed(acc_out)), 8);

    // async reset during HEI wait
    stop();
    sw_flag = 1'b0;
    w(16'h207F); w(16'h4001); w(16'h8000);
    run = 1'b1;
    cyc(20);
    chk("ar_pre_ovf", int'(ovf), 1);
    #2 nReset = 1'b0;
    #1;
    chk("ar_acc", int'(acc_out), 0);
    chk("ar_pc", int'(pc_out), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_halted", int'(halted), 0);
    chk("ar_ovf", int'(ovf), 0);
    run = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;

    // randomized programs and control
    for (int r = 0; r < 25; r++) begin
      stop();
      sw_flag = 1'($urandom_range(0, 1));
      for (int a = 0; a < PD; a++) begin
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'd12 && $urandom_range(0, 3) != 0) rop = 4'd0;
        w({rop, 12'($urandom)});
      end
      run = 1'b1;
      repeat (160) begin
        sw_data = DW'($urandom);
        if ($urandom_range(0, 3) == 0) sw_flag = ~sw_flag;
        if (!run) run = 1'($urandom_range(0, 1));
        else if ($urandom_range(0, 40) == 0) run = 1'b0;
        prog_we = ($urandom_range(0, 9) == 0);
        prog_addr = AW'($urandom);
        prog_data = 16'($urandom);
        @(negedge Clock);
      end
      prog_we = 1'b0;
    end

    run = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
